mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: grant[0] = fetch, grant[1] = load/store.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention goes to whichever port did not win last time.
      2'b11:   grant = (last == OWN_IF) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-outstanding memory
// port, with an ack timeout that turns into an error response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_reg, state_next;
  mem_cmd_t    cmd_reg, cmd_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;
  logic [1:0]  grant;
  logic        busy, resp;

  rr_pick2 u_pick (
    .req   ({ls_req_i, if_req_i}),
    .last  (last_reg),
    .grant (grant)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= '0;
      owner_reg <= OWN_IF;
      last_reg  <= OWN_IF;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    if_gnt_o   = 1'b0;
    ls_gnt_o   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|grant) begin
          if_gnt_o   = grant[0];
          ls_gnt_o   = grant[1];
          owner_next = grant[1] ? OWN_LS : OWN_IF;
          last_next  = owner_next;
          cmd_next   = grant[1] ? {ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i}
                                : {1'b0, 4'hF, if_addr_i, 32'h0};
          cnt_next   = '0;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An ack on the final allowed cycle still counts as a normal response.
        if (mem_ack_i) begin
          rdata_next = mem_rdata_i;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_BUSY);
  assign resp = (state_reg == ST_RESP);

  // Memory-side fields read as zero outside BUSY so nothing leaks after reset.
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & cmd_reg.we;
  assign mem_be_o    = busy ? cmd_reg.be    : 4'h0;
  assign mem_addr_o  = busy ? cmd_reg.addr  : 32'h0;
  assign mem_wdata_o = busy ? cmd_reg.wdata : 32'h0;

  assign if_rvalid_o = resp & (owner_reg == OWN_IF);
  assign ls_rvalid_o = resp & (owner_reg == OWN_LS);
  assign rdata_o     = resp ? rdata_reg : 32'h0;
  assign err_o       = resp & err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model with programmable ack delay
// and a monitor that checks every memory cycle and every response.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic [3:0]  ls_be_i;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 0;
  logic        stray = 1'b0;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr, cur_wdata;
  int          cur_len_exp = 0;
  int          req_len = 0;
  bit          skip_len = 1'b0;
  int          gnt_count = 0;
  exp_t        sb[$];
  logic        grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: ack in BUSY cycle index ack_delay, data = addr + 3.
  initial begin
    int idx;
    idx = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        mem_ack_i   = (idx == ack_delay);
        mem_rdata_i = mem_ack_i ? mem_addr_o + 32'd3 : 32'hBAD0_0BAD;
        idx++;
      end else begin
        mem_ack_i   = stray;
        mem_rdata_i = 32'h5555_AAAA;
        idx = 0;
      end
    end
  end

  // Monitor: pushes expectations on grant, checks memory port and responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (if_gnt_o || ls_gnt_o) begin
        check("gnt_excl", 32'(if_gnt_o & ls_gnt_o), 32'd0);
        if (ls_gnt_o) begin
          cur_we = ls_we_i; cur_be = ls_be_i; cur_addr = ls_addr_i; cur_wdata = ls_wdata_i;
        end else begin
          cur_we = 1'b0; cur_be = 4'hF; cur_addr = if_addr_i; cur_wdata = 32'h0;
        end
        e.owner = ls_gnt_o;
        e.err   = (ack_delay >= int'(TO));
        e.rdata = e.err ? 32'h0 : cur_addr + 32'd3;
        cur_len_exp = e.err ? int'(TO) : ack_delay + 1;
        sb.push_back(e);
        grant_log.push_back(ls_gnt_o);
        gnt_count++;
      end
      if (mem_req_o) begin
        req_len++;
        check("mem_we", 32'(mem_we_o), 32'(cur_we));
        check("mem_be", 32'(mem_be_o), 32'(cur_be));
        check("mem_addr", mem_addr_o, cur_addr);
        check("mem_wdata", mem_wdata_o, cur_wdata);
      end else if (req_len > 0) begin
        if (!skip_len) check("mem_req_len", 32'(req_len), 32'(cur_len_exp));
        req_len = 0;
        skip_len = 1'b0;
      end
      if (if_rvalid_o || ls_rvalid_o) begin
        check("rvalid_excl", 32'(if_rvalid_o & ls_rvalid_o), 32'd0);
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 32'(ls_rvalid_o), 32'(e.owner));
          check("rsp_rdata", rdata_o, e.rdata);
          check("rsp_err", 32'(err_o), 32'(e.err));
          $display("rsp owner=%0d rdata=%h err=%0d", ls_rvalid_o, rdata_o, err_o);
        end
      end
    end
  end

  task automatic issue(input logic port, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input int delay);
    bit ok;
    ack_delay = delay;
    if (port) begin
      ls_req_i = 1'b1; ls_we_i = we; ls_be_i = be; ls_addr_i = addr; ls_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (port ? ls_gnt_o : if_gnt_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_wait", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
    if_req_i = 1'b0; ls_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !mem_req_o && !if_rvalid_o && !ls_rvalid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic run_both(input int n);
    bit ok;
    grant_log.delete();
    gnt_count = 0;
    ack_delay = 0;
    if_addr_i = 32'h200;
    ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h300; ls_wdata_i = 32'h0;
    if_req_i = 1'b1; ls_req_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (gnt_count >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    check("both_grants", 32'(ok), 32'd1);
    wait_idle();
    check("rr_count", 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check("rr_order", 32'(grant_log[i]), 32'((i % 2) == 0));
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      check(tag, {29'b0, if_rvalid_o, ls_rvalid_o, mem_req_o}, 32'd0);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'h0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    #12;
    check("rst_ctrl", {24'b0, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, err_o, mem_req_o, mem_we_o, 1'b0}, 32'd0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_both(4);                                            // ls, if, ls, if
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 2);       // fetch, rdata 0x13
    wait_idle();
    issue(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1);  // store
    wait_idle();
    issue(1'b1, 1'b0, 4'hF, 32'h140, 32'h0, int'(TO) - 1);  // ack on last cycle
    wait_idle();
    issue(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 99);             // timeout
    wait_idle();
    issue(1'b1, 1'b0, 4'hC, 32'h84, 32'h0, 0);              // normal after timeout
    wait_idle();

    stray = 1'b1;                                           // spurious ack in IDLE
    @(posedge clk_i); @(posedge clk_i); #1;
    stray = 1'b0;
    check_quiet("spurious_ack", 3);

    issue(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 99);             // reset mid-BUSY
    @(posedge clk_i); #3;
    skip_len = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("rst_busy_ctrl", {26'b0, if_rvalid_o, ls_rvalid_o, err_o, mem_req_o, mem_we_o, 1'b0}, 32'd0);
    check("rst_busy_addr", mem_addr_o, 32'd0);
    check("rst_busy_be", 32'(mem_be_o), 32'd0);
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    stray = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    stray = 1'b0;
    check_quiet("post_rst_ack", 4);
    run_both(2);                                            // ls wins first again

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
